display_shift_ctrl: RTL and testbench

- Sequences the external 74HC595-style display chain: captures a frame of segment data, shifts it out serially with a generated shift clock, then pulses latch.
- Sits between the time/BCD-to-segment logic and the top-level serial_out / clk_out / latch_out pins.
- Owns all pin timing so the time-keeping datapath only issues refresh requests.

---
 rtl/display_shift_ctrl_pkg.sv | 21 ++
 rtl/display_shift_ctrl_shift_timer.sv | 29 ++
 rtl/display_shift_ctrl.sv | 114 +++++++++++
 tb/tb_display_shift_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_shift_ctrl_pkg.sv
// Shared definitions for the display shift-chain controller: FSM state encoding
// and segment bit positions used by both this block and the BCD-to-segment decoder.
package display_shift_ctrl_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SHIFT_LO = 2'd1;
  localparam logic [1:0] SHIFT_HI = 2'd2;
  localparam logic [1:0] LATCH    = 2'd3;

  // Bit positions inside one 8-bit digit register
  localparam int SEG_A    = 0;
  localparam int SEG_B    = 1;
  localparam int SEG_C    = 2;
  localparam int SEG_D    = 3;
  localparam int SEG_E    = 4;
  localparam int SEG_F    = 5;
  localparam int SEG_G    = 6;
  localparam int SEG_DP   = 7;
  localparam int SEG_BITS = SEG_DP + 1;

endpackage

// File: rtl/display_shift_ctrl_shift_timer.sv
// Loadable down-counter; expire is high in the CLK_DIV-th cycle after a load,
// which paces the shift-clock half-periods and the latch pulse width.
module shift_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (en && cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign expire = en && (cnt == 8'd0);

endmodule

// File: rtl/display_shift_ctrl.sv
// Frame capture and serial shift-out to a 74HC595-style chain, MSB first,
// followed by a storage-register latch pulse.
//
// state    | meaning
// IDLE     | waiting for refresh_req or a pending request
// SHIFT_LO | shift_clk low, serial_out settling for the current bit
// SHIFT_HI | shift_clk high, chain samples serial_out
// LATCH    | latch high, transfers the chain to the display outputs
module display_shift_ctrl
  import display_shift_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    refresh_req,
  input  logic [NUM_DIGITS*8-1:0] seg_data,
  input  logic                    blank,
  output logic                    serial_out,
  output logic                    shift_clk,
  output logic                    latch,
  output logic                    busy,
  output logic                    done
);

  localparam int TOTAL_BITS = NUM_DIGITS * SEG_BITS;
  localparam int BCW        = $clog2(TOTAL_BITS + 1);

  logic [1:0]            state;
  logic [TOTAL_BITS-1:0] frame;
  logic [BCW-1:0]        bits_left;
  logic                  pending;
  logic                  start;
  logic                  expire;
  logic                  tmr_load;
  logic                  last_bit;
  logic [TOTAL_BITS-1:0] capture_val;

  assign start       = (state == IDLE) && (refresh_req || pending);
  // No reload on leaving LATCH so the timer rests at zero while idle
  assign tmr_load    = start || (expire && state != LATCH);
  assign last_bit    = (bits_left == BCW'(1));
  assign capture_val = (blank ? '0 : seg_data) ^ {TOTAL_BITS{SEG_ACTIVE_LOW}};

  shift_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .en     (state != IDLE),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      frame      <= '0;
      bits_left  <= '0;
      pending    <= 1'b0;
      serial_out <= 1'b0;
      shift_clk  <= 1'b0;
      latch      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (refresh_req && state != IDLE) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            frame      <= capture_val;
            serial_out <= capture_val[TOTAL_BITS-1];
            shift_clk  <= 1'b0;
            busy       <= 1'b1;
            pending    <= 1'b0;
            bits_left  <= BCW'(TOTAL_BITS);
            state      <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (expire) begin
            shift_clk <= 1'b1;
            state     <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (expire) begin
            shift_clk <= 1'b0;
            frame     <= frame << 1;
            bits_left <= bits_left - 1'b1;
            if (last_bit) begin
              latch <= 1'b1;
              state <= LATCH;
            end else begin
              serial_out <= frame[TOTAL_BITS-2];
              state      <= SHIFT_LO;
            end
          end
        end
        LATCH: begin
          if (expire) begin
            latch <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_shift_ctrl.sv
// Directed bench for display_shift_ctrl: two instances (CLK_DIV=2 true-polarity,
// CLK_DIV=1 inverted) each feeding a behavioural 595 chain model.
module tb_display_shift_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: CLK_DIV=2, SEG_ACTIVE_LOW=0
  logic        a_reset, a_refresh, a_blank;
  logic [31:0] a_seg;
  logic        a_ser, a_sclk, a_latch, a_busy, a_done;

  display_shift_ctrl #(.NUM_DIGITS(4), .CLK_DIV(2), .SEG_ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .reset(a_reset), .refresh_req(a_refresh), .seg_data(a_seg), .blank(a_blank),
    .serial_out(a_ser), .shift_clk(a_sclk), .latch(a_latch), .busy(a_busy), .done(a_done)
  );

  // Instance B: CLK_DIV=1, SEG_ACTIVE_LOW=1
  logic        b_reset, b_refresh, b_blank;
  logic [31:0] b_seg;
  logic        b_ser, b_sclk, b_latch, b_busy, b_done;

  display_shift_ctrl #(.NUM_DIGITS(4), .CLK_DIV(1), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .reset(b_reset), .refresh_req(b_refresh), .seg_data(b_seg), .blank(b_blank),
    .serial_out(b_ser), .shift_clk(b_sclk), .latch(b_latch), .busy(b_busy), .done(b_done)
  );

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  // 595 chain models
  logic [31:0] a_sr = '0, a_out = '0, b_sr = '0, b_out = '0;
  int a_sclk_cnt = 0, b_sclk_cnt = 0;
  always @(posedge a_sclk) begin a_sr = {a_sr[30:0], a_ser}; a_sclk_cnt++; end
  always @(posedge a_latch) a_out = a_sr;
  always @(posedge b_sclk) begin b_sr = {b_sr[30:0], b_ser}; b_sclk_cnt++; end
  always @(posedge b_latch) b_out = b_sr;

  int   a_run = 0, a_len = 0, a_done_cnt = 0, a_latch_cyc = 0, a_viol = 0;
  logic a_prev_ser = 1'b0, a_done_fall = 1'b0;
  always @(negedge clk) begin
    if (a_busy) a_run++;
    else if (a_run != 0) begin a_len = a_run; a_run = 0; a_done_fall = a_done; end
    if (a_done) a_done_cnt++;
    if (a_latch) a_latch_cyc++;
    if (a_sclk && a_ser !== a_prev_ser) a_viol++;
    a_prev_ser = a_ser;
  end

  int   b_cyc = 0, b_run = 0, b_idle = 0, b_frames = 0, b_len_bad = 0, b_gap_bad = 0;
  int   b_per_bad = 0, b_viol = 0, b_val_bad = 0, b_last_rise = 0;
  logic b_prev_ser = 1'b0, b_prev_sclk = 1'b0, b_rise_seen = 1'b0, b_hold = 1'b0;
  logic [31:0] b_hold_exp = '0;
  always @(negedge clk) begin
    b_cyc++;
    if (b_busy) begin
      if (b_run == 0 && b_hold && b_frames > 0 && b_idle != 1) b_gap_bad++;
      b_run++;
      b_idle = 0;
    end else begin
      if (b_run != 0) begin
        b_frames++;
        if (b_run != 65) b_len_bad++;
        b_run = 0;
      end
      b_idle++;
      b_rise_seen = 1'b0;
    end
    if (b_sclk && !b_prev_sclk) begin
      if (b_rise_seen && (b_cyc - b_last_rise) != 2) b_per_bad++;
      b_rise_seen = 1'b1;
      b_last_rise = b_cyc;
    end
    if (b_hold && b_done && b_out !== b_hold_exp) b_val_bad++;
    if (b_sclk && b_ser !== b_prev_ser) b_viol++;
    b_prev_ser  = b_ser;
    b_prev_sclk = b_sclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_a();
    a_refresh = 1'b1; @(negedge clk); a_refresh = 1'b0;
  endtask

  task automatic pulse_b();
    b_refresh = 1'b1; @(negedge clk); b_refresh = 1'b0;
  endtask

  // Leaves the caller at the negedge where done is high, then scores the latched word
  task automatic wait_done_a(input string tag);
    int n = 0;
    logic [31:0] exp;
    while (!a_done && n < 1000) begin @(negedge clk); n++; end
    chk({tag, "_timeout"}, 32'(n < 1000), 32'd1);
    exp = (qa.size() != 0) ? qa.pop_front() : 'x;
    chk(tag, a_out, exp);
  endtask

  task automatic wait_done_b(input string tag);
    int n = 0;
    logic [31:0] exp;
    while (!b_done && n < 1000) begin @(negedge clk); n++; end
    chk({tag, "_timeout"}, 32'(n < 1000), 32'd1);
    exp = (qb.size() != 0) ? qb.pop_front() : 'x;
    chk(tag, b_out, exp);
  endtask

  task automatic wait_sclk_a(input int target, input string tag);
    int n = 0;
    while (a_sclk_cnt < target && n < 1000) begin @(negedge clk); n++; end
    chk({tag, "_timeout"}, 32'(n < 1000), 32'd1);
  endtask

  task automatic clear_a();
    a_len = 0; a_done_cnt = 0; a_latch_cyc = 0; a_viol = 0; a_sclk_cnt = 0; a_done_fall = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_reset = 1'b1; a_refresh = 1'b0; a_blank = 1'b0; a_seg = '0;
    b_reset = 1'b1; b_refresh = 1'b0; b_blank = 1'b0; b_seg = '0;
    repeat (3) @(negedge clk);
    chk("rst_a_serial", 32'(a_ser), 0);
    chk("rst_a_sclk",   32'(a_sclk), 0);
    chk("rst_a_latch",  32'(a_latch), 0);
    chk("rst_a_busy",   32'(a_busy), 0);
    chk("rst_a_done",   32'(a_done), 0);
    chk("rst_b_busy",   32'(b_busy), 0);
    a_reset = 1'b0; b_reset = 1'b0;
    @(negedge clk);

    // Basic frame
    clear_a();
    a_seg = 32'hA5C3_0F81;
    qa.push_back(32'hA5C3_0F81);
    pulse_a();
    wait_done_a("frame_basic");
    @(negedge clk);
    chk("basic_busy_len",   a_len, 130);
    chk("basic_sclk_rises", a_sclk_cnt, 32);
    chk("basic_latch_cyc",  a_latch_cyc, 2);
    chk("basic_done_cnt",   a_done_cnt, 1);
    chk("basic_done_fall",  32'(a_done_fall), 1);
    chk("basic_ser_stable", a_viol, 0);

    // Blank, true polarity
    a_blank = 1'b1; a_seg = 32'hFFFF_FFFF;
    qa.push_back(32'h0000_0000);
    pulse_a();
    wait_done_a("blank_true");
    a_blank = 1'b0;
    @(negedge clk);

    // Three requests during one frame merge into a single extra frame
    clear_a();
    a_seg = 32'h3C69_E1D2;
    qa.push_back(32'h3C69_E1D2);
    qa.push_back(32'h3C69_E1D2);
    pulse_a();
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      pulse_a();
      repeat (10) @(negedge clk);
    end
    wait_done_a("merge_frame1");
    chk("merge_gap_low", 32'(a_busy), 0);
    @(negedge clk);
    chk("merge_gap_restart", 32'(a_busy), 1);
    wait_done_a("merge_frame2");
    repeat (10) @(negedge clk);
    chk("merge_done_cnt", a_done_cnt, 2);
    chk("merge_no_third", 32'(a_busy), 0);
    chk("merge_q_empty", qa.size(), 0);

    // seg_data change mid-frame does not disturb the frame in flight
    clear_a();
    a_seg = 32'h1234_5678;
    qa.push_back(32'h1234_5678);
    pulse_a();
    wait_sclk_a(10, "midchg_bit10");
    a_seg = 32'h0;
    wait_done_a("midchg_frame");
    @(negedge clk);

    // Reset at shift bit 17 aborts without latch or done
    clear_a();
    a_seg = 32'h5A5A_1234;
    pulse_a();
    wait_sclk_a(17, "abort_bit17");
    a_reset = 1'b1;
    @(negedge clk);
    chk("abort_serial", 32'(a_ser), 0);
    chk("abort_sclk",   32'(a_sclk), 0);
    chk("abort_latch",  32'(a_latch), 0);
    chk("abort_busy",   32'(a_busy), 0);
    chk("abort_done",   32'(a_done), 0);
    a_reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_latch", a_latch_cyc, 0);
    chk("abort_no_done",  a_done_cnt, 0);
    a_seg = 32'hC0FF_EE11;
    qa.push_back(32'hC0FF_EE11);
    pulse_a();
    wait_done_a("after_abort");
    @(negedge clk);

    // Inverted instance: blank sends all ones, data is inverted
    b_blank = 1'b1; b_seg = 32'hFFFF_FFFF;
    qb.push_back(32'hFFFF_FFFF);
    pulse_b();
    wait_done_b("blank_inv");
    b_blank = 1'b0;
    @(negedge clk);
    b_seg = 32'h0F0F_3C3C;
    qb.push_back(32'hF0F0_C3C3);
    pulse_b();
    wait_done_b("data_inv");
    repeat (3) @(negedge clk);

    // refresh_req held high: back-to-back 65-cycle frames with 1-cycle gaps
    b_seg = 32'h8421_7E18;
    b_hold_exp = 32'h7BDE_81E7;
    b_frames = 0; b_len_bad = 0; b_gap_bad = 0; b_per_bad = 0; b_viol = 0; b_val_bad = 0;
    b_sclk_cnt = 0;
    b_hold = 1'b1;
    b_refresh = 1'b1;
    repeat (200) @(negedge clk);
    b_refresh = 1'b0;
    begin
      int n = 0;
      int quiet = 0;
      while (quiet < 3 && n < 300) begin
        @(negedge clk); n++;
        quiet = b_busy ? 0 : quiet + 1;
      end
      chk("hold_drain_timeout", 32'(n < 300), 32'd1);
    end
    b_hold = 1'b0;
    chk("hold_frames_ge3",  32'(b_frames >= 3), 32'd1);
    chk("hold_len_65",      b_len_bad, 0);
    chk("hold_gap_1",       b_gap_bad, 0);
    chk("hold_sclk_period", b_per_bad, 0);
    chk("hold_ser_stable",  b_viol, 0);
    chk("hold_latched_val", b_val_bad, 0);
    chk("hold_sclk_total",  b_sclk_cnt, 32 * b_frames);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
